// File: rtl/onehot_to_bin_16_pkg.sv
// Shared constants and the FIFO entry type for the one-hot digit receive decoder.
package onehot_pkg;

  localparam int DIGITS  = 8;
  localparam int GROUP_W = 4;
  localparam int WORD_W  = DIGITS * GROUP_W;
  localparam int BIN_W   = DIGITS * 2;

  typedef struct packed {
    logic [DIGITS-1:0] err_mask;
    logic [BIN_W-1:0]  data;
  } dec_word_t;

endpackage

// File: rtl/onehot_to_bin_16_if.sv
// Input word and decoded output handshakes of the one-hot receive decoder.
interface onehot_to_bin_16_if;
  import onehot_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [WORD_W-1:0]   in_word;
  logic                out_valid;
  logic                out_ready;
  logic [BIN_W-1:0]    out_data;
  logic                out_err;
  logic [DIGITS-1:0]   out_err_mask;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_err_mask
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_data, out_err, out_err_mask
  );
endinterface

// File: rtl/onehot_digit_dec.sv
// One 4-wire one-hot group to a 2-bit digit, flagging groups that are not exactly one-hot.
module onehot_digit_dec
  import onehot_pkg::*;
(
  input  logic [GROUP_W-1:0] i_grp,
  output logic [1:0]         o_val,
  output logic               o_err
);

  // Malformed groups still decode by the OR rule, so zero-hot gives 0.
  assign o_val[1] = i_grp[2] | i_grp[3];
  assign o_val[0] = i_grp[1] | i_grp[3];

  assign o_err = !((i_grp == 4'b0001) || (i_grp == 4'b0010) ||
                   (i_grp == 4'b0100) || (i_grp == 4'b1000));

endmodule

// File: rtl/onehot_to_bin_16.sv
// Decodes 8-digit one-hot words to 16-bit binary, queues them in a small FIFO,
// and keeps a saturating count of malformed words accepted.
module onehot_to_bin_16
  import onehot_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int STRICT = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  onehot_to_bin_16_if.slave bus,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_F = PTR_W + 1;
  localparam logic [CNT_F-1:0] FULL_LVL = CNT_F'(DEPTH);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

  logic [BIN_W-1:0]  w_data;
  logic [DIGITS-1:0] w_mask;
  dec_word_t         w_dec;
  dec_word_t         w_head;

  dec_word_t         r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_F-1:0]  r_count;
  logic [CNT_W-1:0]  r_err_count;

  logic w_full, w_valid, w_err, w_accept, w_push, w_pop, w_bad_accept;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    onehot_digit_dec u_dec (
      .i_grp (bus.in_word[GROUP_W*k +: GROUP_W]),
      .o_val (w_data[2*k +: 2]),
      .o_err (w_mask[k])
    );
  end

  assign w_dec   = '{err_mask: w_mask, data: w_data};
  assign w_err   = |w_mask;
  assign w_full  = (r_count == FULL_LVL);
  assign w_valid = (r_count != '0);

  // No pass-through: a full FIFO refuses input even when the head is being popped.
  assign bus.in_ready = !w_full && !rst;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_bad_accept = w_accept && w_err;
  assign w_push       = w_accept && ((STRICT == 0) || !w_err);
  assign w_pop        = w_valid && bus.out_ready;

  assign w_head           = r_mem[r_rd_ptr];
  assign bus.out_valid    = w_valid;
  assign bus.out_data     = w_valid ? w_head.data : '0;
  assign bus.out_err_mask = w_valid ? w_head.err_mask : '0;
  assign bus.out_err      = w_valid && (|w_head.err_mask);
  assign err_count        = r_err_count;

  // NOTE: storage has no reset; the count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dec;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (err_clr) begin
      r_err_count <= w_bad_accept ? CNT_W'(1) : '0;
    end else if (w_bad_accept && (r_err_count != ERR_MAX)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_onehot_to_bin_16.sv
// Directed-vector bench for onehot_to_bin_16: default, STRICT=1 and CNT_W=2 instances.
module tb_onehot_to_bin_16;

  logic clk = 1'b0;
  logic rst;
  logic clr0, clr1, clr2;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  onehot_to_bin_16_if b0 ();
  onehot_to_bin_16_if b1 ();
  onehot_to_bin_16_if b2 ();

  onehot_to_bin_16 #(.DEPTH(2), .STRICT(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(b0), .err_clr(clr0), .err_count(cnt0));
  onehot_to_bin_16 #(.DEPTH(2), .STRICT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .err_clr(clr1), .err_count(cnt1));
  onehot_to_bin_16 #(.DEPTH(2), .STRICT(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2), .err_clr(clr2), .err_count(cnt2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Head of dut0: valid, data, err, mask.
  task automatic check_head0(input string tag, input logic v, input logic [15:0] d,
                             input logic e, input logic [7:0] m);
    check({tag, ".valid"}, 32'(b0.out_valid), 32'(v));
    check({tag, ".data"},  32'(b0.out_data),  32'(d));
    check({tag, ".err"},   32'(b0.out_err),   32'(e));
    check({tag, ".mask"},  32'(b0.out_err_mask), 32'(m));
  endtask

  logic [31:0] bad_words [5] = '{32'h11111110, 32'h1111111C, 32'h11111130,
                                 32'h00000000, 32'h11111111};
  logic [1:0]  sat_exp   [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    rst = 1'b1;
    {clr0, clr1, clr2} = '0;
    {b0.in_valid, b0.out_ready, b1.in_valid, b1.out_ready, b2.in_valid, b2.out_ready} = '0;
    b0.in_word = '0; b1.in_word = '0; b2.in_word = '0;

    tick(); tick();
    check("rst.in_ready", 32'(b0.in_ready), 32'd0);
    check_head0("rst", 1'b0, 16'h0000, 1'b0, 8'h00);
    check("rst.err_count", 32'(cnt0), 32'd0);
    rst = 1'b0;
    #1;
    check("rel.in_ready", 32'(b0.in_ready), 32'd1);

    // Single well-formed word, FIFO empty: visible one cycle later.
    tick();
    b0.out_ready = 1'b1;
    b0.in_valid  = 1'b1;
    b0.in_word   = 32'h12141821;
    tick();
    b0.in_valid = 1'b0;
    check_head0("w1234", 1'b1, 16'h1234, 1'b0, 8'h00);
    check("w1234.err_count", 32'(cnt0), 32'd0);
    tick();
    check("w1234.drained", 32'(b0.out_valid), 32'd0);

    // Back-to-back throughput.
    b0.in_valid = 1'b1;
    b0.in_word  = 32'h11111111;
    tick();
    check_head0("b2b0", 1'b1, 16'h0000, 1'b0, 8'h00);
    check("b2b0.in_ready", 32'(b0.in_ready), 32'd1);
    b0.in_word = 32'h88888888;
    tick();
    check_head0("b2bF", 1'b1, 16'hFFFF, 1'b0, 8'h00);
    check("b2bF.in_ready", 32'(b0.in_ready), 32'd1);
    b0.in_valid = 1'b0;
    tick();
    check("b2b.drained", 32'(b0.out_valid), 32'd0);

    // Malformed words pushed when STRICT=0.
    b0.in_valid = 1'b1;
    b0.in_word  = 32'h11111110;
    tick();
    check_head0("zero_hot", 1'b1, 16'h0000, 1'b1, 8'h01);
    b0.in_word = 32'h1111111C;
    tick();
    check_head0("multi_hot", 1'b1, 16'h0003, 1'b1, 8'h01);
    b0.in_valid = 1'b0;
    tick();
    check("bad.err_count", 32'(cnt0), 32'd2);
    check("bad.drained", 32'(b0.out_valid), 32'd0);

    // Backpressure with DEPTH=2 and three words offered.
    b0.out_ready = 1'b0;
    b0.in_valid  = 1'b1;
    b0.in_word   = 32'h11111112;
    tick();
    check("bp.ready1", 32'(b0.in_ready), 32'd1);
    b0.in_word = 32'h11111114;
    tick();
    check("bp.full", 32'(b0.in_ready), 32'd0);
    check("bp.head", 32'(b0.out_data), 32'h0001);
    b0.in_word = 32'h11111118;
    tick();
    check("bp.hold_ready", 32'(b0.in_ready), 32'd0);
    check("bp.hold_head", 32'(b0.out_data), 32'h0001);
    b0.out_ready = 1'b1;
    tick();
    check("bp.drain1", 32'(b0.out_data), 32'h0002);
    check("bp.ready2", 32'(b0.in_ready), 32'd1);
    tick();
    b0.in_valid = 1'b0;
    check("bp.drain2", 32'(b0.out_data), 32'h0003);
    check("bp.valid2", 32'(b0.out_valid), 32'd1);
    tick();
    check("bp.empty", 32'(b0.out_valid), 32'd0);
    check("bp.err_count", 32'(cnt0), 32'd2);

    // Clear coinciding with a malformed accept, then clear alone.
    clr0 = 1'b1;
    b0.in_valid = 1'b1;
    b0.in_word  = 32'h11111110;
    tick();
    b0.in_valid = 1'b0;
    check("clr_bad", 32'(cnt0), 32'd1);
    tick();
    clr0 = 1'b0;
    check("clr_alone", 32'(cnt0), 32'd0);

    // STRICT=1 drops malformed words but still counts them.
    b1.out_ready = 1'b1;
    b1.in_valid  = 1'b1;
    b1.in_word   = 32'h11111110;
    tick();
    check("strict.drop0", 32'(b1.out_valid), 32'd0);
    b1.in_word = 32'h1111111C;
    tick();
    check("strict.drop1", 32'(b1.out_valid), 32'd0);
    b1.in_word = 32'h12141821;
    tick();
    b1.in_valid = 1'b0;
    check("strict.valid", 32'(b1.out_valid), 32'd1);
    check("strict.data", 32'(b1.out_data), 32'h1234);
    check("strict.err_count", 32'(cnt1), 32'd2);
    tick();
    check("strict.empty", 32'(b1.out_valid), 32'd0);

    // CNT_W=2 saturates at 3.
    b2.out_ready = 1'b1;
    b2.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b2.in_word = bad_words[i];
      tick();
      check($sformatf("sat%0d", i), 32'(cnt2), 32'(sat_exp[i]));
    end
    b2.in_valid = 1'b0;

    // Reset asserted with two words queued and a nonzero count.
    b0.out_ready = 1'b0;
    b0.in_valid  = 1'b1;
    b0.in_word   = 32'h11111110;
    tick();
    b0.in_word = 32'h12141821;
    tick();
    b0.in_valid = 1'b0;
    check("pre_rst.valid", 32'(b0.out_valid), 32'd1);
    check("pre_rst.err_count", 32'(cnt0), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_head0("async_rst", 1'b0, 16'h0000, 1'b0, 8'h00);
    check("async_rst.err_count", 32'(cnt0), 32'd0);
    check("async_rst.in_ready", 32'(b0.in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst.in_ready", 32'(b0.in_ready), 32'd1);
    tick();
    check("post_rst.valid", 32'(b0.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
